// File: rtl/booth_pkg.sv
// Shared definitions for the iterative radix-4 Booth multiplier:
// FSM states, Booth digit codes and the iteration-count helper.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } digit_t;

    // One radix-4 digit per bit pair of the (width+2)-bit extended multiplier.
    function automatic int booth_iter(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_pp.sv
// Radix-4 Booth partial-product generator: recodes one 3-bit multiplier
// window and produces digit * multiplicand, unshifted.
module booth_r4_pp
    import booth_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic        [2:0]       window,
    input  logic        [WIDTH+1:0] mcand,
    output logic signed [WIDTH+2:0] pp
);

    digit_t           digit;
    logic [WIDTH+2:0] m1;
    logic [WIDTH+2:0] m2;

    // The extended multiplicand is always read as signed; one extra bit keeps +/-2A in range.
    assign m1 = {mcand[WIDTH+1], mcand};
    assign m2 = {mcand, 1'b0};

    always_comb begin
        digit = ZERO;
        case (window)
            3'b001, 3'b010: digit = POS1;
            3'b011:         digit = POS2;
            3'b100:         digit = NEG2;
            3'b101, 3'b110: digit = NEG1;
            default:        digit = ZERO;
        endcase
    end

    always_comb begin
        pp = '0;
        case (digit)
            POS1:    pp = m1;
            POS2:    pp = m2;
            NEG1:    pp = -m1;
            NEG2:    pp = -m2;
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier: one partial product per clock,
// runtime signed/unsigned mode, valid/ready on both sides.
module booth_mul_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int ITER  = booth_iter(WIDTH);
    localparam int XW    = WIDTH + 2;
    localparam int ACC_W = 2 * WIDTH + 4;
    localparam int CW    = $clog2(ITER + 1);
    localparam logic [CW-1:0] LAST = CW'(ITER);

    state_t              state;
    state_t              state_next;
    logic [XW-1:0]       a_ext;
    logic [XW:0]         b_sh;
    logic [ACC_W-1:0]    acc;
    logic [CW-1:0]       cnt;
    logic [2*WIDTH-1:0]  product_q;
    logic                out_valid_q;
    logic signed [XW:0]  pp;
    logic [ACC_W-1:0]    pp_wide;
    logic [ACC_W-1:0]    pp_shifted;
    logic [XW-1:0]       a_cap;
    logic [XW-1:0]       b_cap;

    assign a_cap = is_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
    assign b_cap = is_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};

    // b_sh carries the implicit b[-1]=0 in its LSB, so the window is always b_sh[2:0].
    booth_r4_pp #(
        .WIDTH (WIDTH)
    ) u_pp (
        .window (b_sh[2:0]),
        .mcand  (a_ext),
        .pp     (pp)
    );

    assign pp_wide    = {{(ACC_W - XW - 1){pp[XW]}}, pp};
    assign pp_shifted = pp_wide << {cnt, 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = CALC;
            CALC:    if (cnt == LAST) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The extra CALC cycle with cnt==LAST moves the finished sum into the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_ext       <= '0;
            b_sh        <= '0;
            acc         <= '0;
            cnt         <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_ext <= a_cap;
                        b_sh  <= {b_cap, 1'b0};
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    if (cnt == LAST) begin
                        product_q <= acc[2*WIDTH-1:0];
                    end else begin
                        acc  <= acc + pp_shifted;
                        cnt  <= cnt + CW'(1);
                        b_sh <= b_sh >> 2;
                    end
                end
                default: ;
            endcase
            out_valid_q <= (state_next == DONE);
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = out_valid_q;
    assign product   = product_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: directed corner cases on WIDTH=16,
// randomized traffic on WIDTH 8/16/32 against an arithmetic reference.
module tb_booth_mul_seq;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic        in_valid  [3];
    logic [63:0] a_in      [3];
    logic [63:0] b_in      [3];
    logic        sgn       [3];
    logic        out_ready [3];
    logic        in_rdy    [3];
    logic        out_vld   [3];
    logic        bsy       [3];
    logic [15:0] prod8;
    logic [31:0] prod16;
    logic [63:0] prod32;

    int checks = 0;
    int errors = 0;
    int xfers [3] = '{0, 0, 0};
    int accepts [3] = '{0, 0, 0};

    booth_mul_seq #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[0]),
        .in_ready  (in_rdy[0]),
        .a         (a_in[0][7:0]),
        .b         (b_in[0][7:0]),
        .is_signed (sgn[0]),
        .out_valid (out_vld[0]),
        .out_ready (out_ready[0]),
        .product   (prod8),
        .busy      (bsy[0])
    );

    booth_mul_seq #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[1]),
        .in_ready  (in_rdy[1]),
        .a         (a_in[1][15:0]),
        .b         (b_in[1][15:0]),
        .is_signed (sgn[1]),
        .out_valid (out_vld[1]),
        .out_ready (out_ready[1]),
        .product   (prod16),
        .busy      (bsy[1])
    );

    booth_mul_seq #(.WIDTH(32)) dut32 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[2]),
        .in_ready  (in_rdy[2]),
        .a         (a_in[2][31:0]),
        .b         (b_in[2][31:0]),
        .is_signed (sgn[2]),
        .out_valid (out_vld[2]),
        .out_ready (out_ready[2]),
        .product   (prod32),
        .busy      (bsy[2])
    );

    // Count completed output transfers per instance, independent of the stimulus tasks.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                if (out_vld[i] && out_ready[i]) xfers[i]++;
            end
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [63:0] get_prod(input int i);
        case (i)
            0:       return {48'd0, prod8};
            1:       return {32'd0, prod16};
            default: return prod32;
        endcase
    endfunction

    function automatic int width_of(input int i);
        case (i)
            0:       return 8;
            1:       return 16;
            default: return 32;
        endcase
    endfunction

    // Reference: interpret operands per mode, multiply in 64-bit, keep 2*w bits.
    function automatic logic [63:0] ref_mul(input int w, input logic [63:0] a,
                                            input logic [63:0] b, input logic s);
        logic [63:0]        mask;
        logic [63:0]        pmask;
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0]        p;
        mask  = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        pmask = (2 * w >= 64) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
        if (s) begin
            sa = $signed(a << (64 - w)) >>> (64 - w);
            sb = $signed(b << (64 - w)) >>> (64 - w);
        end else begin
            sa = a & mask;
            sb = b & mask;
        end
        p = sa * sb;
        return p & pmask;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for in_ready, presents one operation for a single accept edge, then scrambles the inputs.
    task automatic applyStimulus(input int i, input logic [63:0] a, input logic [63:0] b, input logic s);
        int n;
        n = 0;
        while (!in_rdy[i] && n < 100) begin
            tick();
            n++;
        end
        checkOutput($sformatf("accept_ready_w%0d", width_of(i)), 64'(in_rdy[i]), 64'd1);
        a_in[i]     = a;
        b_in[i]     = b;
        sgn[i]      = s;
        in_valid[i] = 1'b1;
        tick();
        in_valid[i] = 1'b0;
        accepts[i]++;
        a_in[i] = {$urandom, $urandom};
        b_in[i] = {$urandom, $urandom};
        sgn[i]  = ~s;
    endtask

    task automatic collectResult(input int i, input logic [63:0] exp, input string tag, input bit rnd_ready);
        int n;
        bit done;
        n    = 0;
        done = 0;
        while (!done && n < 300) begin
            out_ready[i] = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_vld[i] && out_ready[i]) begin
                checkOutput(tag, get_prod(i), exp);
                done = 1;
            end
            tick();
            n++;
        end
        if (!done) checkOutput({tag, "_timeout"}, 64'd0, 64'd1);
        out_ready[i] = 1'b1;
    endtask

    initial begin
        int n;
        int bad;
        int base;
        logic [63:0] pexp;
        logic [63:0] ra;
        logic [63:0] rb;
        logic        rs;
        int nops;

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            a_in[i]      = '0;
            b_in[i]      = '0;
            sgn[i]       = 1'b0;
            out_ready[i] = 1'b1;
        end
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("reset_in_ready_w%0d", width_of(i)), 64'(in_rdy[i]), 64'd1);
            checkOutput($sformatf("reset_out_valid_w%0d", width_of(i)), 64'(out_vld[i]), 64'd0);
            checkOutput($sformatf("reset_busy_w%0d", width_of(i)), 64'(bsy[i]), 64'd0);
            checkOutput($sformatf("reset_product_w%0d", width_of(i)), get_prod(i), 64'd0);
        end
        rst = 1'b0;
        tick();

        // Latency and drain timing on the 16-bit instance.
        applyStimulus(1, 64'h6080, 64'h8001, 1'b1);
        checkOutput("calc_busy", 64'(bsy[1]), 64'd1);
        checkOutput("calc_in_ready", 64'(in_rdy[1]), 64'd0);
        n = 0;
        while (!out_vld[1] && n < 50) begin
            tick();
            n++;
        end
        checkOutput("latency", 64'(n), 64'd10);
        checkOutput("directed_product", get_prod(1), 64'hCFC06080);
        tick();
        checkOutput("drain_in_ready", 64'(in_rdy[1]), 64'd1);
        checkOutput("drain_out_valid", 64'(out_vld[1]), 64'd0);

        applyStimulus(1, 64'hFFFF, 64'hFFFF, 1'b1);
        collectResult(1, 64'h00000001, "ones_signed", 0);
        applyStimulus(1, 64'hFFFF, 64'hFFFF, 1'b0);
        collectResult(1, 64'hFFFE0001, "ones_unsigned", 0);
        applyStimulus(1, 64'h8000, 64'h8000, 1'b1);
        collectResult(1, 64'h40000000, "min_signed", 0);
        applyStimulus(1, 64'h0000, 64'h1234, 1'b1);
        collectResult(1, 64'h0, "zero_a", 0);
        applyStimulus(1, 64'hFFFF, 64'h0000, 1'b0);
        collectResult(1, 64'h0, "zero_b", 0);

        // Backpressure: hold the result, ignore new requests, then drain exactly once.
        out_ready[1] = 1'b0;
        applyStimulus(1, 64'h1234, 64'h5678, 1'b0);
        n = 0;
        while (!out_vld[1] && n < 50) begin
            tick();
            n++;
        end
        pexp = 64'h1234 * 64'h5678;
        checkOutput("bp_product", get_prod(1), pexp);
        base = xfers[1];
        bad  = 0;
        for (int c = 0; c < 20; c++) begin
            in_valid[1] = 1'($urandom_range(0, 1));
            a_in[1]     = {$urandom, $urandom};
            tick();
            if (out_vld[1] !== 1'b1 || get_prod(1) !== pexp || in_rdy[1] !== 1'b0) bad++;
        end
        checkOutput("bp_unstable_cycles", 64'(bad), 64'd0);
        in_valid[1]  = 1'b0;
        out_ready[1] = 1'b1;
        tick();
        checkOutput("bp_drain_valid", 64'(out_vld[1]), 64'd0);
        repeat (3) tick();
        checkOutput("bp_transfers", 64'(xfers[1] - base), 64'd1);
        checkOutput("bp_idle_busy", 64'(bsy[1]), 64'd0);

        // Reset at CALC cycle 4 discards the operation.
        applyStimulus(1, 64'hABCD, 64'h1357, 1'b1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst_in_ready", 64'(in_rdy[1]), 64'd1);
        checkOutput("midrst_busy", 64'(bsy[1]), 64'd0);
        checkOutput("midrst_out_valid", 64'(out_vld[1]), 64'd0);
        checkOutput("midrst_product", get_prod(1), 64'd0);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (out_vld[1]) bad++;
        end
        checkOutput("midrst_late_valid", 64'(bad), 64'd0);

        // Reset coinciding with an accept wins.
        a_in[1]     = 64'h00FF;
        b_in[1]     = 64'h00FF;
        in_valid[1] = 1'b1;
        rst         = 1'b1;
        tick();
        rst         = 1'b0;
        in_valid[1] = 1'b0;
        checkOutput("rst_accept_busy", 64'(bsy[1]), 64'd0);
        bad = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (out_vld[1]) bad++;
        end
        checkOutput("rst_accept_late_valid", 64'(bad), 64'd0);

        // Randomized traffic on all three widths with random consumer stalls.
        for (int i = 0; i < 3; i++) begin
            nops = (i == 1) ? 400 : 300;
            base = xfers[i];
            n    = accepts[i];
            for (int k = 0; k < nops; k++) begin
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
                rs = 1'($urandom_range(0, 1));
                if (k % 8 == 0) begin
                    case ($urandom_range(0, 2))
                        0:       ra = '0;
                        1:       ra = '1;
                        default: ra = 64'd1 << (width_of(i) - 1);
                    endcase
                    case ($urandom_range(0, 2))
                        0:       rb = '1;
                        1:       rb = 64'd1 << (width_of(i) - 1);
                        default: rb = '0;
                    endcase
                end
                repeat ($urandom_range(0, 2)) tick();
                pexp = ref_mul(width_of(i), ra, rb, rs);
                applyStimulus(i, ra, rb, rs);
                collectResult(i, pexp, $sformatf("rand_w%0d_op%0d", width_of(i), k), 1);
            end
            tick();
            checkOutput($sformatf("rand_w%0d_xfer_count", width_of(i)),
                        64'(xfers[i] - base), 64'(accepts[i] - n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
